// File: rtl/product_cpa64.sv
// Final carry-propagate adder behind the Wallace CSA tree: folds sums + (couts<<1)
// into a 64-bit product, CHUNK_W bits per cycle, with a valid/ready handshake on both sides.
module product_cpa64 #(
  parameter int CHUNK_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] sums,
  input  logic [63:0] couts,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);
  localparam int NCHUNK = 64 / CHUNK_W;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_next;
  logic [63:0]         r_a, r_b, r_product;
  logic [KW-1:0]       r_k;
  logic                r_carry;
  logic [CHUNK_W-1:0]  w_a_sl, w_b_sl;
  logic [CHUNK_W:0]    w_sum;
  logic                w_accept, w_last;
  logic                w_unused_cout_msb;

  // couts[63] would land at weight 2^64, outside the product.
  assign w_unused_cout_msb = couts[63];

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_last   = (r_k == KW'(NCHUNK - 1));
  assign w_a_sl   = r_a[r_k*CHUNK_W +: CHUNK_W];
  assign w_b_sl   = r_b[r_k*CHUNK_W +: CHUNK_W];
  assign w_sum    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK_W{1'b0}}, r_carry};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ADD) || (r_state == S_DONE);
  assign product   = r_product;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_ADD;
      S_ADD:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Flush leaves the partially written product in place; only k and carry restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_k       <= '0;
      r_carry   <= 1'b0;
      r_product <= '0;
    end else if (flush) begin
      r_k     <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_a     <= sums;
      r_b     <= {couts[62:0], 1'b0};
      r_k     <= '0;
      r_carry <= 1'b0;
    end else if (r_state == S_ADD) begin
      r_product[r_k*CHUNK_W +: CHUNK_W] <= w_sum[CHUNK_W-1:0];
      r_carry <= w_sum[CHUNK_W];
      r_k     <= w_last ? '0 : r_k + KW'(1);
    end
  end
endmodule

// File: tb/tb_product_cpa64.sv
// Directed and random checks of product_cpa64: handshake timing, stall, flush,
// async reset, and back-to-back operation at three slice widths.
module tb_product_cpa64;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [63:0] sums, couts;
  logic        in_ready, out_valid, busy;
  logic [63:0] product;

  int n_chk, n_fail;

  always #5 clk = ~clk;

  product_cpa64 dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .sums(sums), .couts(couts),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  // Random back-to-back instances: index 0 -> 8-bit, 1 -> 16-bit, 2 -> 64-bit slices.
  logic        rv_iv[3], rv_ir[3], rv_ov[3], rv_bsy[3];
  logic [63:0] rv_s[3], rv_c[3], rv_p[3];

  product_cpa64 #(.CHUNK_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(rv_iv[0]), .in_ready(rv_ir[0]), .sums(rv_s[0]), .couts(rv_c[0]),
    .out_valid(rv_ov[0]), .out_ready(1'b1), .product(rv_p[0]), .busy(rv_bsy[0])
  );
  product_cpa64 #(.CHUNK_W(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(rv_iv[1]), .in_ready(rv_ir[1]), .sums(rv_s[1]), .couts(rv_c[1]),
    .out_valid(rv_ov[1]), .out_ready(1'b1), .product(rv_p[1]), .busy(rv_bsy[1])
  );
  product_cpa64 #(.CHUNK_W(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(rv_iv[2]), .in_ready(rv_ir[2]), .sums(rv_s[2]), .couts(rv_c[2]),
    .out_valid(rv_ov[2]), .out_ready(1'b1), .product(rv_p[2]), .busy(rv_bsy[2])
  );

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic accept_pair(input logic [63:0] s, input logic [63:0] c);
    @(negedge clk);
    in_valid = 1'b1; sums = s; couts = c;
    chk1("accept_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; sums = ~s; couts = ~c;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk1("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic release_out;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [63:0] s, input logic [63:0] c,
                        input logic [63:0] exp);
    int lat;
    accept_pair(s, c);
    wait_valid(lat);
    check({name, "_product"}, product, exp);
    check({name, "_latency"}, 64'(lat), 64'd4);
    chk1({name, "_ready_in_done"}, in_ready, 1'b0);
    release_out();
    chk1({name, "_ready_after"}, in_ready, 1'b1);
    chk1({name, "_valid_after"}, out_valid, 1'b0);
  endtask

  task automatic run_rnd(input int g, input int ops);
    logic [63:0] q[$];
    int nacc, nblk, cyc, nch;
    nch = (g == 0) ? 8 : (g == 1) ? 4 : 1;
    nacc = 0; nblk = 0; cyc = 0;
    while ((nacc < ops || q.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (rv_ov[g]) begin
        if (q.size() != 0) check($sformatf("rnd%0d_product", g), rv_p[g], q.pop_front());
        else               chk1($sformatf("rnd%0d_spurious_valid", g), rv_ov[g], 1'b0);
      end
      if (rv_ir[g]) begin
        if (nacc > 0) check($sformatf("rnd%0d_blocked_cycles", g), 64'(nblk), 64'(nch + 1));
        nblk = 0;
        if (nacc < ops) begin
          rv_s[g] = {$urandom, $urandom};
          rv_c[g] = {$urandom, $urandom};
          q.push_back(rv_s[g] + {rv_c[g][62:0], 1'b0});
          rv_iv[g] = 1'b1;
          nacc++;
        end else rv_iv[g] = 1'b0;
      end else begin
        nblk++;
        rv_s[g] = {$urandom, $urandom};
        rv_c[g] = {$urandom, $urandom};
      end
    end
    rv_iv[g] = 1'b0;
    if (cyc >= 2000) check($sformatf("rnd%0d_timeout", g), 64'(q.size()), 64'd0);
  endtask

  vec_t        vecs[8];
  logic [63:0] pv, expv;
  int          lat;
  logic        seen;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sums = '0; couts = '0;
    for (int g = 0; g < 3; g++) begin
      rv_iv[g] = 1'b0; rv_s[g] = '0; rv_c[g] = '0;
    end

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h1};
    vecs[1] = '{64'h0,                   64'h8000_0000_0000_0000, 64'h0};
    vecs[2] = '{64'h5,                   64'h3,                   64'hB};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h10,                  64'h1234_5678_9ABC_DF10};
    vecs[4] = '{64'h0000_0000_FFFF_FFFF, 64'h8000_0000,           64'h0000_0001_FFFF_FFFF};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h2AAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[7] = '{64'h0000_FFFF_0000_FFFF, 64'h8000_0000,           64'h0001_0000_0000_FFFF};

    // Reset state, with a pair offered that must not be taken
    in_valid = 1'b1; sums = 64'h77; couts = 64'h1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    check("rst_product", product, 64'h0);

    // Accept on the first edge after release
    @(negedge clk);
    rst_n = 1'b1; sums = 64'h5; couts = 64'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("first_edge_busy", busy, 1'b1);
    wait_valid(lat);
    check("first_edge_product", product, 64'hB);
    check("first_edge_latency", 64'(lat), 64'd4);
    release_out();

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].exp);

    // Output stall with in_valid asserted during DONE
    expv = 64'h1111_2222_3333_4444 + 64'h0246_8ACF_1357_9BDE;
    accept_pair(64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF);
    wait_valid(lat);
    check("stall_product", product, expv);
    in_valid = 1'b1; sums = 64'hDEAD_BEEF_0000_0001; couts = 64'h5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1($sformatf("stall%0d_valid", i), out_valid, 1'b1);
      check($sformatf("stall%0d_product", i), product, expv);
      chk1($sformatf("stall%0d_in_ready", i), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    release_out();
    chk1("stall_ready_after", in_ready, 1'b1);
    check("stall_product_held", product, expv);

    // Flush on the second ADD cycle: only slice 0 of the new sum lands
    pv = product;
    expv = 64'hFFFF_0000_1234_00FF + 64'h0000_0000_0000_0102;
    accept_pair(64'hFFFF_0000_1234_00FF, 64'h81);
    @(posedge clk); #1;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk1("flush_in_ready", in_ready, 1'b1);
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_out_valid", out_valid, 1'b0);
    check("flush_product_partial", product, {pv[63:16], expv[15:0]});
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk1("flush_no_valid", seen, 1'b0);
    run_op("post_flush", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h1_0001);

    // Flush in IDLE beats in_valid
    pv = product;
    @(negedge clk); in_valid = 1'b1; flush = 1'b1; sums = 64'h42; couts = 64'h0;
    @(posedge clk); #1;
    chk1("idle_flush_busy", busy, 1'b0);
    chk1("idle_flush_in_ready", in_ready, 1'b1);
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_product", product, pv);

    // Async reset in the middle of ADD
    accept_pair(64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_in_ready", in_ready, 1'b1);
    chk1("arst_out_valid", out_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    check("arst_product", product, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid | busy;
    end
    chk1("arst_no_activity", seen, 1'b0);
    run_op("post_arst", vecs[3].s, vecs[3].c, vecs[3].exp);

    for (int g = 0; g < 3; g++) run_rnd(g, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/product_cpa64.md
PRODUCT_CPA64 -- requirements
Module: product_cpa64

Interface
REQ-001 SHALL have parameter CHUNK_W, default 16, adder slice width per cycle; legal values 8, 16, 32, 64.
REQ-002 SHALL derive localparam NCHUNK = 64/CHUNK_W, the number of add cycles per operation.
REQ-003 SHALL use a single clock with asynchronous active-low reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous abort of any operation in flight.
REQ-007 in_valid  input  1  sums/couts pair from the Wallace CSA tree is valid.
REQ-008 in_ready  output  1  block can accept a pair.
REQ-009 sums  input  64  CSA sum vector, bit i at weight 2^i.
REQ-010 couts  input  64  CSA carry vector, bit i at weight 2^(i+1).
REQ-011 out_valid  output  1  product is valid.
REQ-012 out_ready  input  1  consumer accepts the product.
REQ-013 product  output  64  registered final product.
REQ-014 busy  output  1  high in ADD or DONE.

Function
REQ-015 SHALL compute product = (sums + {couts[62:0],1'b0}) mod 2^64; couts[63] and the final carry SHALL be discarded.
REQ-016 SHALL implement states IDLE, ADD and DONE in a 2-bit state register.
REQ-017 In IDLE, in_ready SHALL be 1; in ADD and DONE it SHALL be 0.
REQ-018 On an edge with in_valid && in_ready, SHALL latch A=sums and B={couts[62:0],1'b0}, clear chunk index k and carry, and enter ADD.
REQ-019 In ADD, each edge SHALL write result[k*CHUNK_W +: CHUNK_W] = A slice + B slice + carry, register the slice carry-out, and increment k.
REQ-020 When k = NCHUNK-1 in ADD, the same edge SHALL complete the last slice and enter DONE.
REQ-021 out_valid SHALL equal (state == DONE) and rise exactly NCHUNK edges after the accepting edge (4 for the default).
REQ-022 In DONE, product SHALL hold stable until out_valid && out_ready; that edge SHALL return to IDLE.
REQ-023 There SHALL be no same-cycle accept on the DONE->IDLE edge; minimum initiation interval is NCHUNK+1 cycles.
REQ-024 in_valid, sums and couts SHALL be ignored outside IDLE; A and B SHALL not change during ADD.
REQ-025 flush SHALL override all handshakes: the next state is IDLE and out_valid is 0 next cycle, k and carry are cleared, and product retains its last value.
REQ-026 flush in IDLE with in_valid high SHALL NOT accept the pair.
REQ-027 product SHALL change only during ADD slice writes; slices not yet written SHALL hold their previous values until overwritten.

Reset
REQ-028 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, k=0, carry=0, A=B=0.
REQ-029 Reset asserted mid-ADD or mid-DONE SHALL abort immediately, with no output handshake.
REQ-030 After reset deassertion, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 sums=64'hFFFF_FFFF_FFFF_FFFF, couts=64'h1 -> product=64'h0000_0000_0000_0001; the carry ripples through all slices; out_valid rises 4 edges after accept.
REQ-032 sums=0, couts=64'h8000_0000_0000_0000 -> product=0 (couts[63] dropped); sums=64'h5, couts=64'h3 -> product=64'hB.
REQ-033 out_ready held low 6 cycles in DONE -> out_valid and product stable throughout, in_ready=0; one cycle after the out_ready pulse, in_ready=1.
REQ-034 flush asserted on the 2nd ADD cycle -> IDLE next cycle, out_valid never rises; a following pair computes correctly.
REQ-035 rst_n pulsed low mid-ADD -> all outputs at reset values asynchronously; no out_valid until a new accept.
REQ-036 Random back-to-back sums/couts with in_valid held high and out_ready=1, compared against the 64-bit model, for CHUNK_W = 8, 16 and 64 -> zero mismatches, interval NCHUNK+1.
